// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the floating-point adder datapath.
// Field widths, the packed IEEE-754 word layout and the +inf constant.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int FRAC_W = MANT_W - 1;

  localparam logic [EXP_W-1:0] EXP_INF = '1;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] fract;
  } fp32_t;

  localparam logic [31:0] PINF = 32'h7F80_0000;

  function automatic fp32_t pack_fp32(input logic              sign,
                                      input logic [EXP_W-1:0]  exp,
                                      input logic [FRAC_W-1:0] fract);
    fp32_t w;
    w.sign  = sign;
    w.exp   = exp;
    w.fract = fract;
    return w;
  endfunction

endpackage

// File: rtl/fp_pipe_reg.sv
// Generic valid/ready register slice: one entry, full throughput, the
// upstream ready depends only on the local valid and downstream ready.
module fp_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_adv;

  // The slice can take a new entry when it is empty or its entry leaves now.
  assign w_adv   = !r_valid || i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // NOTE: state registers use non-blocking assignments so every slice samples
  // its neighbour's pre-edge value; blocking here would race between slices.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      // NOTE: the payload is cleared too, so the output word reads zero after
      // reset instead of showing stale or unknown data.
      r_data  <= '0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/fpadd_mantsum.sv
// Final stage of the positive-operand FP adder: mantissa add, one-bit
// renormalize on carry, exponent overflow to +inf, and IEEE-754 packing.
module fpadd_mantsum
  import fp_pkg::fp32_t;
  import fp_pkg::pack_fp32;
  import fp_pkg::PINF;
#(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int MANT_W = fp_pkg::MANT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              alessb,
  input  logic [MANT_W-1:0] manta,
  input  logic [MANT_W-1:0] mantb,
  input  logic [MANT_W-1:0] shmant,
  input  logic [EXP_W-1:0]  exp_big,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              ovf
);

  localparam int S1_W = (MANT_W + 1) + EXP_W + 1;
  localparam int S2_W = 32 + 1;

  // Stage 1 inputs: pick the unshifted mantissa and form the full-width sum.
  logic [MANT_W-1:0] w_big;
  logic [MANT_W:0]   w_sum;
  logic              w_special;

  assign w_big     = alessb ? mantb : manta;
  assign w_sum     = {1'b0, w_big} + {1'b0, shmant};
  assign w_special = (exp_big == {EXP_W{1'b1}});

  logic [S1_W-1:0] w_s1_out;
  logic            w_s1_valid;
  logic            w_s2_ready;

  fp_pipe_reg #(.W(S1_W)) u_s1 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  ({w_sum, exp_big, w_special}),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_out)
  );

  logic [MANT_W:0]   w_s1_sum;
  logic [EXP_W-1:0]  w_s1_exp;
  logic              w_s1_special;

  assign w_s1_sum     = w_s1_out[S1_W-1 -: MANT_W+1];
  assign w_s1_exp     = w_s1_out[EXP_W:1];
  assign w_s1_special = w_s1_out[0];

  // Renormalize: a carry-out shifts right by one and drops the LSB unrounded.
  logic [EXP_W:0]    w_exp_inc;
  logic [MANT_W-2:0] w_fract;
  logic [31:0]       w_res;
  logic              w_ovf;
  fp32_t             w_packed;

  assign w_exp_inc = {1'b0, w_s1_exp} + {{EXP_W{1'b0}}, w_s1_sum[MANT_W]};
  assign w_fract   = w_s1_sum[MANT_W] ? w_s1_sum[MANT_W-1:1] : w_s1_sum[MANT_W-2:0];
  assign w_packed  = pack_fp32(1'b0, w_exp_inc[EXP_W-1:0], w_fract);

  always_comb begin
    // NOTE: defaults come first so every path assigns both outputs and no
    // latch is inferred.
    w_res = w_packed;
    w_ovf = 1'b0;
    if (w_s1_special) begin
      w_res = PINF;
    end else if (w_exp_inc >= {1'b0, {EXP_W{1'b1}}}) begin
      w_res = PINF;
      w_ovf = 1'b1;
    end
  end

  logic [S2_W-1:0] w_s2_out;

  fp_pipe_reg #(.W(S2_W)) u_s2 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  ({w_res, w_ovf}),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_s2_out)
  );

  assign result = w_s2_out[S2_W-1:1];
  assign ovf    = w_s2_out[0];

endmodule

// File: doc/fpadd_mantsum.md
# fpadd_mantsum

Final stage of the single-precision floating-point adder for positive operands. It sits directly downstream of the mantissa alignment shifter. It adds the unshifted mantissa of the larger operand to the aligned (shifted) mantissa and renormalizes on carry-out. It then packs sign, exponent and fraction into an IEEE-754 word. The datapath is a 2-stage valid/ready pipeline so the adder can be stalled by the writeback path.

## Interface
- EXP_W, 8, exponent width
- MANT_W, 24, mantissa width including hidden 1; fraction width is MANT_W-1
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  upstream holds a valid operand set
- in_ready  output  1  stage can accept this cycle
- alessb  input  1  1: operand A is smaller, so B is unshifted; 0: A is unshifted
- manta, mantb  input  MANT_W  hidden-1 mantissas of A and B
- shmant  input  MANT_W  aligned mantissa of the smaller operand (0 if fully shifted out)
- exp_big  input  EXP_W  exponent of the larger operand
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  32  packed {1'b0, exp, fract}
- ovf  output  1  exponent overflowed to infinity on this result

## Operation
- Stage 1 (S1), on accept (in_valid & in_ready):
  - register big = alessb ? mantb : manta.
  - register sum = big + shmant, MANT_W+1 bits, zero-extended, no truncation.
  - register exp_big.
  - register special = (exp_big == all-ones).
- Stage 2 (S2), on S1→S2 transfer:
  - if sum[MANT_W]: fract = sum[MANT_W-1:1], exp = exp_big + 1. The dropped LSB is truncated; there is no rounding.
  - else: fract = sum[MANT_W-2:0], exp = exp_big.
  - exponent increment is EXP_W+1 bits wide.
  - if special: result = {0, all-ones, 0}, ovf = 0. Inf/NaN inputs collapse to +inf.
  - else if exp (EXP_W+1 bits) ≥ all-ones: result = {0, all-ones, 0}, ovf = 1.
  - else: result = {0, exp[EXP_W-1:0], fract}, ovf = 0.
- Sign bit is always 0. Operands are positive by contract.
- Zero/denormal operands are not supported. Behaviour with a hidden bit of 0 is undefined, but no X must propagate.

## Timing
- Latency: 2 cycles from accept to out_valid when unstalled; throughput 1/cycle.
- s2_adv = !s2_valid | out_ready
- s1_adv = !s1_valid | s2_adv
- in_ready = s1_adv. This is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- Handshake rules:
  - While out_valid & !out_ready: result and ovf hold stable.
  - out_valid never drops until the result is accepted.
- Simultaneous events: an output accept and a new S1→S2 transfer in the same cycle are both honoured with no bubble.
- Full: both stages valid and out_ready = 0 → in_ready = 0. The first out_ready = 1 cycle re-opens in_ready that same cycle.
- Reset, including mid-stall:
  - next edge clears s1_valid, s2_valid, and all data regs to 0.
  - out_valid = 0, result = 32'h0, ovf = 0.
  - in_ready = 1 in the first cycle after reset.
  - in-flight data is discarded.
- reset has priority over any handshake in the same cycle.

## Structure
- Shared package fp_pkg:
  - EXP_W, MANT_W, FRAC_W
  - EXP_INF (all-ones)
  - typedef fp32_t packed {sign, exp, fract}
  - function pack_fp32
  - PINF constant 32'h7F80_0000
- Sub-module fp_pipe_reg: generic valid/ready register slice, parameterized data width, with synchronous reset of the valid flag and the data.
  - Instantiated twice: S1 payload {sum, exp_big, special}; S2 payload {result, ovf}.
  - Add and normalize logic stays in fpadd_mantsum between the two slices.

## Test plan
- 1.0 + 1.0: manta = mantb = shmant = 24'h800000, alessb = 0, exp_big = 127 → two cycles later result = 32'h4000_0000, ovf = 0.
- 1.5 + 0.25: manta = 24'hC00000, shmant = 24'h200000, alessb = 0, exp_big = 127 → result = 32'h3FE0_0000. Repeat with alessb = 1 and the mantissa on mantb for the same result.
- Overflow: manta = shmant = 24'h800000, exp_big = 254 → result = 32'h7F80_0000, ovf = 1. Also exp_big = 255 → result = 32'h7F80_0000, ovf = 0.
- Backpressure:
  - Stream 4 back-to-back inputs with out_ready = 0 → exactly 2 accepted, in_ready = 0 from then on.
  - Raise out_ready → all 4 results emerge in order, each held stable until accepted, with no drops or duplicates.
- Reset mid-stall: pipeline full, out_ready = 0, assert reset 1 cycle → out_valid = 0, result = 0, in_ready = 1. The next single input appears 2 cycles after accept.
- Random stream: 10k positive normal operand pairs with random out_ready. Compare against a truncating reference model of the same contract, checking order and values.
